// File: rtl/bus_initiator.sv
`timescale 1ns/1ps
// bus_initiator
// Runs one 68030-style asynchronous bus operand transfer (byte, word, 3-byte
// or long, read or write) and splits it into as many bus cycles as the
// responding port width and the address alignment require.
// Ports:
//   CLK, nRST            system clock, asynchronous active-low reset
//   REQ, REQ_RnW,        operation request (sampled in IDLE only), direction,
//   REQ_SIZ, REQ_ADDR,   68030 size code, operand byte address,
//   WDATA                right-justified write operand
//   DATA_IN              bus data D31:0
//   nDSACK, nBERR        asynchronous bus terminations
//   nAS, nDS, RnW, SIZ,  bus strobes, direction, bytes remaining,
//   ADDR, DOUT, DOE      bus address, write data lanes, data output enable
//   BUSY, DONE, ERR,     operation status; DONE pulses one cycle at the end
//   RDATA                right-justified read result
module bus_initiator #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        REQ,
  input  logic        REQ_RnW,
  input  logic [1:0]  REQ_SIZ,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] WDATA,
  input  logic [31:0] DATA_IN,
  input  logic [1:0]  nDSACK,
  input  logic        nBERR,
  output logic        nAS,
  output logic        nDS,
  output logic        RnW,
  output logic [1:0]  SIZ,
  output logic [31:0] ADDR,
  output logic [31:0] DOUT,
  output logic        DOE,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [31:0] RDATA
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    S_ADDR   = 3'd1,
    S_STROBE = 3'd2,
    S_WAIT   = 3'd3,
    S_TERM   = 3'd4,
    S_RECOV  = 3'd5
  } state_t;

  // Bytes moved by one acknowledged cycle: limited by what remains and by
  // how far the port's width extends past the current address.
  function automatic logic [2:0] f_xfer_bytes(input logic [1:0] ack,
                                              input logic [2:0] rem,
                                              input logic [1:0] a);
    logic [2:0] cap;
    case (ack)
      2'b00:   cap = 3'd4 - {1'b0, a};
      2'b01:   cap = 3'd2 - {2'b00, a[0]};
      2'b10:   cap = 3'd1;
      default: cap = 3'd1;
    endcase
    return (rem < cap) ? rem : cap;
  endfunction

  // First data lane (0 = D31:24) the responding port uses at this address.
  function automatic logic [2:0] f_start_lane(input logic [1:0] ack,
                                              input logic [1:0] a);
    case (ack)
      2'b00:   return {1'b0, a};
      2'b01:   return {2'b00, a[0]};
      default: return 3'd0;
    endcase
  endfunction

  // Write lane replication so any port width finds its bytes on its lanes.
  function automatic logic [31:0] f_write_lanes(input logic [31:0] wbuf,
                                                input logic [1:0]  a);
    logic [7:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = wbuf;
    case (a)
      2'b00:   return {w0, w1, w2, w3};
      2'b01:   return {w0, w0, w1, w2};
      2'b10:   return {w0, w1, w0, w1};
      2'b11:   return {w0, w0, w1, w0};
      default: return {w0, w1, w2, w3};
    endcase
  endfunction

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_dsack_meta, r_dsack_sync;
  logic          r_berr_meta, r_berr_sync;
  logic          r_rnw_op, w_rnw_op_nxt;
  logic [31:0]   r_addr, w_addr_nxt;
  logic [2:0]    r_rem, w_rem_nxt;
  logic [2:0]    r_n, w_n_nxt;
  logic [31:0]   r_wbuf, w_wbuf_nxt;
  logic [31:0]   r_acc, w_acc_nxt;
  logic          r_err_op, w_err_op_nxt;
  logic [TW-1:0] r_tmo, w_tmo_nxt, w_tmo_inc;
  logic          r_done, w_done_nxt;
  logic          r_err_o, w_err_o_nxt;
  logic [31:0]   r_rdata, w_rdata_nxt;
  logic          r_nas, r_nds, r_rnw_o, r_doe, r_busy;
  logic [31:0]   r_dout;
  logic [2:0]    w_n, w_lane;
  logic [31:0]   w_bytes, w_acc_upd, w_wdata_lj;

  // Two-flop synchronizers for the asynchronous terminations.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_dsack_meta <= 2'b11;
      r_dsack_sync <= 2'b11;
      r_berr_meta  <= 1'b1;
      r_berr_sync  <= 1'b1;
    end else begin
      r_dsack_meta <= nDSACK;
      r_dsack_sync <= r_dsack_meta;
      r_berr_meta  <= nBERR;
      r_berr_sync  <= r_berr_meta;
    end
  end

  // Per-cycle datapath values derived from the synchronized acknowledge.
  always_comb begin
    w_n        = f_xfer_bytes(r_dsack_sync, r_rem, r_addr[1:0]);
    w_lane     = f_start_lane(r_dsack_sync, r_addr[1:0]);
    // Move the first valid lane to the MSB, then right-justify n bytes.
    w_bytes    = (DATA_IN << {w_lane, 3'b000}) >> {3'd4 - w_n, 3'b000};
    w_acc_upd  = (r_acc << {w_n, 3'b000}) | w_bytes;
    w_tmo_inc  = r_tmo + TW'(1);
    case (REQ_SIZ)
      2'b01:   w_wdata_lj = WDATA << 24;
      2'b10:   w_wdata_lj = WDATA << 16;
      2'b11:   w_wdata_lj = WDATA << 8;
      default: w_wdata_lj = WDATA;
    endcase
  end

  // Next-state and next-datapath decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_rnw_op_nxt = r_rnw_op;
    w_addr_nxt   = r_addr;
    w_rem_nxt    = r_rem;
    w_n_nxt      = r_n;
    w_wbuf_nxt   = r_wbuf;
    w_acc_nxt    = r_acc;
    w_err_op_nxt = r_err_op;
    w_tmo_nxt    = r_tmo;
    w_done_nxt   = 1'b0;
    w_err_o_nxt  = r_err_o;
    w_rdata_nxt  = r_rdata;
    case (r_state)
      IDLE: begin
        if (REQ) begin
          w_rnw_op_nxt = REQ_RnW;
          w_addr_nxt   = REQ_ADDR;
          w_rem_nxt    = (REQ_SIZ == 2'b00) ? 3'd4 : {1'b0, REQ_SIZ};
          w_wbuf_nxt   = w_wdata_lj;
          w_acc_nxt    = 32'd0;
          w_err_op_nxt = 1'b0;
          w_err_o_nxt  = 1'b0;
          w_n_nxt      = 3'd0;
          w_state_nxt  = S_ADDR;
        end else begin
          w_state_nxt  = IDLE;
        end
      end
      S_ADDR:   w_state_nxt = S_STROBE;
      S_STROBE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        // Bus error wins over a simultaneous acknowledge.
        if (!r_berr_sync) begin
          w_err_op_nxt = 1'b1;
          w_n_nxt      = 3'd0;
          w_state_nxt  = S_TERM;
        end else if (r_dsack_sync != 2'b11) begin
          w_n_nxt      = w_n;
          w_acc_nxt    = r_rnw_op ? w_acc_upd : r_acc;
          w_state_nxt  = S_TERM;
        end else if (w_tmo_inc == TMO_LIMIT) begin
          w_err_op_nxt = 1'b1;
          w_n_nxt      = 3'd0;
          w_tmo_nxt    = w_tmo_inc;
          w_state_nxt  = S_TERM;
        end else begin
          w_tmo_nxt    = w_tmo_inc;
        end
      end
      S_TERM: begin
        w_addr_nxt  = r_addr + {29'd0, r_n};
        w_rem_nxt   = r_rem - r_n;
        w_wbuf_nxt  = r_wbuf << {r_n, 3'b000};
        w_tmo_nxt   = '0;
        w_state_nxt = S_RECOV;
      end
      S_RECOV: begin
        if ((r_rem != 3'd0) && !r_err_op) begin
          w_state_nxt = S_ADDR;
        end else begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
          w_err_o_nxt = r_err_op;
          w_rdata_nxt = r_acc;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_rnw_op <= 1'b1;
      r_addr   <= 32'd0;
      r_rem    <= 3'd0;
      r_n      <= 3'd0;
      r_wbuf   <= 32'd0;
      r_acc    <= 32'd0;
      r_err_op <= 1'b0;
      r_tmo    <= '0;
      r_done   <= 1'b0;
      r_err_o  <= 1'b0;
      r_rdata  <= 32'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_rnw_op <= w_rnw_op_nxt;
      r_addr   <= w_addr_nxt;
      r_rem    <= w_rem_nxt;
      r_n      <= w_n_nxt;
      r_wbuf   <= w_wbuf_nxt;
      r_acc    <= w_acc_nxt;
      r_err_op <= w_err_op_nxt;
      r_tmo    <= w_tmo_nxt;
      r_done   <= w_done_nxt;
      r_err_o  <= w_err_o_nxt;
      r_rdata  <= w_rdata_nxt;
    end
  end

  // Bus control outputs, registered from the state being entered.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_nas   <= 1'b1;
      r_nds   <= 1'b1;
      r_rnw_o <= 1'b1;
      r_doe   <= 1'b0;
      r_busy  <= 1'b0;
      r_dout  <= 32'd0;
    end else begin
      r_nas   <= !((w_state_nxt == S_STROBE) || (w_state_nxt == S_WAIT));
      // Writes hold off the data strobe until the data lanes have settled.
      r_nds   <= !(((w_state_nxt == S_STROBE) && w_rnw_op_nxt) ||
                   (w_state_nxt == S_WAIT));
      r_rnw_o <= (w_state_nxt == IDLE) ? 1'b1 : w_rnw_op_nxt;
      r_doe   <= !w_rnw_op_nxt && ((w_state_nxt == S_ADDR) ||
                 (w_state_nxt == S_STROBE) || (w_state_nxt == S_WAIT) ||
                 (w_state_nxt == S_TERM));
      r_busy  <= (w_state_nxt != IDLE);
      r_dout  <= f_write_lanes(w_wbuf_nxt, w_addr_nxt[1:0]);
    end
  end

  assign nAS   = r_nas;
  assign nDS   = r_nds;
  assign RnW   = r_rnw_o;
  assign SIZ   = r_rem[1:0];
  assign ADDR  = r_addr;
  assign DOUT  = r_dout;
  assign DOE   = r_doe;
  assign BUSY  = r_busy;
  assign DONE  = r_done;
  assign ERR   = r_err_o;
  assign RDATA = r_rdata;

endmodule

// File: tb/tb_bus_initiator.sv
`timescale 1ns/1ps
// Self-checking bench for bus_initiator: a byte-memory bus responder with
// selectable port width, wait states and error behaviour, plus an
// operand-level model (memory bytes in, memory bytes out).
module tb_bus_initiator;

  logic        CLK = 1'b0;
  logic        nRST, REQ, REQ_RnW, nBERR;
  logic [1:0]  REQ_SIZ, nDSACK;
  logic [31:0] REQ_ADDR, WDATA, DATA_IN;
  logic        nAS, nDS, RnW, DOE, BUSY, DONE, ERR;
  logic [1:0]  SIZ;
  logic [31:0] ADDR, DOUT, RDATA;

  bus_initiator #(.TIMEOUT(255)) dut (
    .CLK(CLK), .nRST(nRST), .REQ(REQ), .REQ_RnW(REQ_RnW), .REQ_SIZ(REQ_SIZ),
    .REQ_ADDR(REQ_ADDR), .WDATA(WDATA), .DATA_IN(DATA_IN), .nDSACK(nDSACK),
    .nBERR(nBERR), .nAS(nAS), .nDS(nDS), .RnW(RnW), .SIZ(SIZ), .ADDR(ADDR),
    .DOUT(DOUT), .DOE(DOE), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RDATA(RDATA)
  );

  always #10 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0]  mem [256];
  logic [31:0] m_addr;
  int          m_rem;
  logic        m_rnw;
  int          port_mode = 0;   // 0:32-bit 1:16-bit 2:8-bit 3:random per cycle
  int          err_mode  = 0;   // 0:normal 1:BERR with DSACK=00 2:never respond
  int          max_wait  = 0;
  logic [31:0] log_addr [$];
  logic [31:0] log_dout [$];
  logic [1:0]  log_siz  [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [31:0] addr, input int r);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < r; i++) v = (v << 8) | {24'd0, mem[8'(addr + 32'(i))]};
    return v;
  endfunction

  // Bus responder and per-bus-cycle comparator.
  initial begin : agent
    int port, wcnt, n, a, first;
    bit active, acked;
    logic [31:0] d;
    nDSACK = 2'b11; nBERR = 1'b1; DATA_IN = 32'd0;
    active = 1'b0; acked = 1'b0; n = 0; port = 0; wcnt = 0;
    forever begin
      @(negedge CLK);
      if (nRST !== 1'b1) begin
        nDSACK = 2'b11; nBERR = 1'b1; active = 1'b0; acked = 1'b0;
      end else if (active && nAS === 1'b1) begin
        nDSACK = 2'b11; nBERR = 1'b1; active = 1'b0;
        if (acked && err_mode == 0) begin
          m_addr = m_addr + 32'(n);
          m_rem  = m_rem - n;
        end
        acked = 1'b0;
      end else begin
        if (!active && nAS === 1'b0) begin
          active = 1'b1; acked = 1'b0;
          port = (port_mode == 3) ? int'($urandom_range(0, 2)) : port_mode;
          wcnt = (max_wait == 0) ? 0 : int'($urandom_range(0, max_wait));
          chk("bus_addr", ADDR, m_addr);
          chk("bus_siz", {30'd0, SIZ}, 32'(m_rem % 4));
          chk("bus_rnw", {31'd0, RnW}, {31'd0, m_rnw});
          chk("bus_doe", {31'd0, DOE}, {31'd0, ~m_rnw});
          log_addr.push_back(ADDR); log_siz.push_back(SIZ); log_dout.push_back(DOUT);
        end
        if (active && !acked && err_mode != 2) begin
          if (wcnt > 0) wcnt--;
          else begin
            a = int'(m_addr[1:0]);
            if (port == 0) n = (m_rem < 4 - a) ? m_rem : 4 - a;
            else if (port == 1) n = (m_rem < 2 - (a % 2)) ? m_rem : 2 - (a % 2);
            else n = 1;
            first = (port == 0) ? a : (port == 1) ? (a % 2) : 0;
            if (err_mode == 1) begin
              nBERR = 1'b0; nDSACK = 2'b00;
            end else begin
              nDSACK = (port == 0) ? 2'b00 : (port == 1) ? 2'b01 : 2'b10;
              if (m_rnw) begin
                d = $urandom;
                if (port == 0)
                  for (int k = 0; k < 4; k++) d[31-8*k -: 8] = mem[8'((m_addr & ~32'd3) + 32'(k))];
                else if (port == 1)
                  for (int k = 0; k < 2; k++) d[31-8*k -: 8] = mem[8'((m_addr & ~32'd1) + 32'(k))];
                else
                  d[31:24] = mem[8'(m_addr)];
                DATA_IN = d;
              end else begin
                for (int i = 0; i < n; i++) mem[8'(m_addr + 32'(i))] = DOUT[31-8*(first+i) -: 8];
              end
            end
            acked = 1'b1;
          end
        end
      end
    end
  end

  task automatic run_op(input bit rnw, input logic [1:0] siz, input logic [31:0] addr,
                        input logic [31:0] wdata, output bit done_seen, output int strobe_low);
    int c;
    @(negedge CLK);
    m_addr = addr; m_rem = (siz == 2'b00) ? 4 : int'(siz); m_rnw = rnw;
    log_addr.delete(); log_siz.delete(); log_dout.delete();
    REQ = 1'b1; REQ_RnW = rnw; REQ_SIZ = siz; REQ_ADDR = addr; WDATA = wdata;
    @(negedge CLK);
    REQ = 1'b0;
    chk("busy_after_req", {31'd0, BUSY}, 32'd1);
    done_seen = 1'b0; strobe_low = 0; c = 0;
    while (!done_seen && c < 2000) begin
      if (DONE === 1'b1) done_seen = 1'b1;
      else begin
        if (nAS === 1'b0) strobe_low++;
        // A request while busy must be ignored.
        REQ = (c == 2);
        if (c == 2) begin REQ_ADDR = $urandom; WDATA = $urandom; REQ_RnW = ~rnw; end
        @(negedge CLK);
        c++;
      end
    end
    REQ = 1'b0;
    if (!done_seen) begin
      n_vec++; n_bad++;
      $display("FAIL done_timeout: no DONE within 2000 cycles");
    end else begin
      chk("busy_at_done", {31'd0, BUSY}, 32'd0);
      @(negedge CLK);
      chk("done_pulse", {31'd0, DONE}, 32'd0);
    end
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    bit ok;
    int sl, r;
    logic [31:0] a32, wd, ev;
    logic [1:0] sz;
    bit rw;
    nRST = 1'b0; REQ = 1'b0; REQ_RnW = 1'b1; REQ_SIZ = 2'b00;
    REQ_ADDR = 32'd0; WDATA = 32'd0;
    m_addr = 32'd0; m_rem = 0; m_rnw = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge CLK);
    chk("rst_nas", {31'd0, nAS}, 32'd1);
    chk("rst_nds", {31'd0, nDS}, 32'd1);
    chk("rst_rnw", {31'd0, RnW}, 32'd1);
    chk("rst_doe_busy_done_err", {28'd0, DOE, BUSY, DONE, ERR}, 32'd0);
    chk("rst_siz", {30'd0, SIZ}, 32'd0);
    chk("rst_addr", ADDR, 32'd0);
    chk("rst_dout", DOUT, 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    nRST = 1'b1;

    // Long read, 32-bit port.
    port_mode = 0; max_wait = 0; err_mode = 0;
    mem[8'h00] = 8'hDE; mem[8'h01] = 8'hAD; mem[8'h02] = 8'hBE; mem[8'h03] = 8'hEF;
    run_op(1'b1, 2'b00, 32'h0000_1000, 32'd0, ok, sl);
    chk("r32_cycles", 32'(log_addr.size()), 32'd1);
    chk("r32_siz", {30'd0, log_siz[0]}, 32'd0);
    chk("r32_rdata", RDATA, 32'hDEAD_BEEF);
    chk("r32_err", {31'd0, ERR}, 32'd0);
    repeat (3) @(negedge CLK);
    chk("rdata_hold", RDATA, 32'hDEAD_BEEF);

    // Long write, 16-bit port.
    port_mode = 1;
    run_op(1'b0, 2'b00, 32'h0000_2000, 32'h1122_3344, ok, sl);
    chk("w16_cycles", 32'(log_addr.size()), 32'd2);
    chk("w16_a0", log_addr[0], 32'h0000_2000);
    chk("w16_s0", {30'd0, log_siz[0]}, 32'd0);
    chk("w16_d0", log_dout[0], 32'h1122_3344);
    chk("w16_a1", log_addr[1], 32'h0000_2002);
    chk("w16_s1", {30'd0, log_siz[1]}, 32'd2);
    chk("w16_d1", log_dout[1], 32'h3344_3344);

    // Misaligned long read, 8-bit port.
    port_mode = 2;
    mem[8'h01] = 8'hAA; mem[8'h02] = 8'hBB; mem[8'h03] = 8'hCC; mem[8'h04] = 8'hDD;
    run_op(1'b1, 2'b00, 32'h0000_3001, 32'd0, ok, sl);
    chk("r8_cycles", 32'(log_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_addr.size()) begin
        chk("r8_addr", log_addr[i], 32'h0000_3001 + 32'(i));
        chk("r8_siz", {30'd0, log_siz[i]}, 32'((4 - i) % 4));
      end else begin
        chk("r8_missing_cycle", 32'(log_addr.size()), 32'd4);
      end
    end
    chk("r8_rdata", RDATA, 32'hAABB_CCDD);

    // Word write crossing a longword, 32-bit port.
    port_mode = 0;
    run_op(1'b0, 2'b10, 32'h0000_4003, 32'h0000_5566, ok, sl);
    chk("w32_cycles", 32'(log_addr.size()), 32'd2);
    chk("w32_s0", {30'd0, log_siz[0]}, 32'd2);
    chk("w32_d0", log_dout[0], 32'h5555_6655);
    chk("w32_a1", log_addr[1], 32'h0000_4004);
    chk("w32_s1", {30'd0, log_siz[1]}, 32'd1);
    chk("w32_d1", log_dout[1], 32'h6600_0000);
    chk("w32_mem", {mem[8'h03], mem[8'h04]}, 32'h0000_5566);

    // No response: self-generated bus error after 255 wait cycles.
    err_mode = 2;
    run_op(1'b1, 2'b00, 32'h0000_5000, 32'd0, ok, sl);
    chk("tmo_err", {31'd0, ERR}, 32'd1);
    chk("tmo_strobe_cycles", 32'(sl), 32'd256);

    // Bus error together with DSACK=00.
    err_mode = 1;
    run_op(1'b1, 2'b00, 32'h0000_5100, 32'd0, ok, sl);
    chk("berr_err", {31'd0, ERR}, 32'd1);

    // Reset in the middle of a wait.
    err_mode = 2;
    @(negedge CLK);
    m_addr = 32'h0000_6000; m_rem = 4; m_rnw = 1'b1;
    REQ = 1'b1; REQ_RnW = 1'b1; REQ_SIZ = 2'b00; REQ_ADDR = 32'h0000_6000;
    @(negedge CLK);
    REQ = 1'b0;
    repeat (6) @(negedge CLK);
    chk("nas_in_wait", {31'd0, nAS}, 32'd0);
    #3 nRST = 1'b0;
    #1;
    chk("rst_mid_nas_nds", {30'd0, nAS, nDS}, 32'd3);
    chk("rst_mid_busy_done", {30'd0, BUSY, DONE}, 32'd0);
    repeat (3) begin
      @(negedge CLK);
      chk("rst_mid_no_done", {31'd0, DONE}, 32'd0);
    end
    #2 nRST = 1'b1;
    err_mode = 0; port_mode = 0;
    run_op(1'b1, 2'b00, 32'h0000_6000, 32'd0, ok, sl);
    chk("after_rst_rdata", RDATA, exp_read(32'h0000_6000, 4));
    chk("after_rst_err", {31'd0, ERR}, 32'd0);

    // Randomized operands, port widths and wait states.
    port_mode = 3; max_wait = 2; err_mode = 0;
    for (int t = 0; t < 40; t++) begin
      rw  = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      a32 = {$urandom_range(0, 32'hFF_FFFF), 8'($urandom_range(0, 250))};
      wd  = $urandom;
      r   = (sz == 2'b00) ? 4 : int'(sz);
      if (!rw)
        for (int i = 0; i < r; i++) mem[8'(a32 + 32'(i))] = ~8'(wd >> (8 * (r - 1 - i)));
      ev = exp_read(a32, r);
      run_op(rw, sz, a32, wd, ok, sl);
      chk("rnd_err", {31'd0, ERR}, 32'd0);
      if (rw) chk("rnd_rdata", RDATA, ev);
      else
        for (int i = 0; i < r; i++)
          chk("rnd_wbyte", {24'd0, mem[8'(a32 + 32'(i))]}, {24'd0, 8'(wd >> (8 * (r - 1 - i)))});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_initiator.md
BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: CLK and nRST. CLK is the 50 MHz system clock.
REQ-002 Port list (name, direction, width, meaning):
- CLK  in  1  system clock.
- nRST  in  1  asynchronous active-low reset.
- REQ  in  1  start request, sampled in IDLE only.
- REQ_RnW  in  1  1=read, 0=write.
- REQ_SIZ  in  2  operand size in 68030 encoding: 01=byte, 10=word, 11=3-byte, 00=long.
- REQ_ADDR  in  32  operand byte address.
- WDATA  in  32  write operand, right-justified.
- DATA_IN  in  32  bus data D31:0.
- nDSACK  in  2  {nDSACK1,nDSACK0}, asynchronous.
- nBERR  in  1  bus error, asynchronous.
- nAS, nDS  out  1  address and data strobes.
- RnW  out  1  bus read/write.
- SIZ  out  2  bytes remaining.
- ADDR  out  32  bus address.
- DOUT  out  32  write data lanes.
- DOE  out  1  data output enable.
- BUSY  out  1  operation in progress.
- DONE  out  1  completion pulse.
- ERR  out  1  operation terminated by bus error.
- RDATA  out  32  read result, right-justified.
REQ-003 Parameter: TIMEOUT, default 255, meaning S_WAIT cycles before a self-generated bus error.

Function
REQ-004 nDSACK and nBERR SHALL each pass through a two-flop synchronizer before use.
REQ-005 State machine: IDLE, S_ADDR, S_STROBE, S_WAIT, S_TERM, S_RECOV.
REQ-006 In IDLE, REQ=1 SHALL capture RnW, SIZ and ADDR; compute remaining count R (long=4); load WBUF = WDATA left-justified, so the first byte is in [31:24]; clear the RDATA accumulator; go to S_ADDR. REQ outside IDLE SHALL be ignored.
REQ-007 S_ADDR SHALL drive ADDR, SIZ=R mod 4, RnW, and for writes DOE=1 and DOUT, then go to S_STROBE.
REQ-008 S_STROBE SHALL assert nAS=0. Reads also assert nDS=0 in S_STROBE; writes assert nDS=0 from S_WAIT onward.
REQ-009 S_WAIT, per synchronized sample:
- nBERR=0 -> S_TERM with error.
- nDSACK=00 -> 32-bit port.
- nDSACK=01 -> 16-bit port.
- nDSACK=10 -> 8-bit port.
- nDSACK=11 -> wait and increment the timeout counter; reaching TIMEOUT -> S_TERM with error.
- nBERR SHALL take priority over a simultaneous DSACK.
REQ-010 Bytes transferred n, with A = ADDR[1:0]:
- 32-bit port: min(R, 4-A).
- 16-bit port: min(R, 2-A[0]).
- 8-bit port: 1.
REQ-011 Reads SHALL take the n bytes from DATA_IN, in the cycle DSACK is recognised, at these lanes (lane 0 = D31:24):
- 32-bit port: lanes A..A+n-1.
- 16-bit port: lanes A[0]..A[0]+n-1.
- 8-bit port: lane 0.
The accumulator update is acc = (acc<<8n) | bytes.
REQ-012 Write lanes SHALL follow this table, with W0..W3 = WBUF bytes from the MSB:
- A=00: W0 W1 W2 W3.
- A=01: W0 W0 W1 W2.
- A=10: W0 W1 W0 W1.
- A=11: W0 W0 W1 W0.
REQ-013 S_TERM SHALL negate nAS and nDS, update ADDR+=n, R-=n and WBUF<<=8n (zero-filled), clear the timeout counter, and go to S_RECOV.
REQ-014 S_RECOV SHALL branch as follows:
- R>0 and no error -> S_ADDR.
- Otherwise -> IDLE, with DONE=1 for exactly one cycle, ERR valid that cycle, and RDATA=acc right-justified.
REQ-015 ERR and RDATA SHALL hold until the next accepted REQ. BUSY=1 in every state except IDLE. DOE SHALL drop in S_RECOV.
REQ-016 Minimum cycle with zero wait states is 5 clocks per bus cycle (S_ADDR..S_RECOV), plus 2 clocks of synchronizer latency.
REQ-017 A misaligned operand SHALL never issue a bus cycle with SIZ=00 crossing a longword on a 32-bit port; crossing is resolved by the n rule.

Reset
REQ-018 While nRST=0, regardless of state, the block SHALL hold:
- state=IDLE, nAS=1, nDS=1, RnW=1, DOE=0, BUSY=0, DONE=0, ERR=0.
- SIZ=00, ADDR=0, DOUT=0, RDATA=0.
- Synchronizers at inactive (1), timeout counter=0.
REQ-019 Reset asserted mid-cycle SHALL negate the strobes immediately and SHALL produce no DONE.

Verification
REQ-020 Long read at 0x00001000, nDSACK=00, DATA_IN=0xDEADBEEF -> one bus cycle, SIZ=00, RDATA=0xDEADBEEF, DONE pulse, ERR=0.
REQ-021 Long write 0x11223344 at 0x00002000 on a 16-bit port -> cycle 1: ADDR 0x2000, SIZ=00, DOUT=0x11223344; cycle 2: ADDR 0x2002, SIZ=10, DOUT=0x33443344.
REQ-022 Long read at 0x00003001 on an 8-bit port with bytes AA,BB,CC,DD -> four cycles, ADDR 3001..3004, SIZ 00,11,10,01, RDATA=0xAABBCCDD.
REQ-023 Word write 0x5566 at 0x00004003 on a 32-bit port -> cycle 1: SIZ=10, DOUT=0x55556655; cycle 2: ADDR 0x4004, SIZ=01, DOUT=0x66000000.
REQ-024 nDSACK held at 11 -> after 255 S_WAIT cycles the strobes negate, DONE=1 with ERR=1. Separately, nBERR=0 together with nDSACK=00 -> ERR=1.
REQ-025 nRST pulsed low during S_WAIT -> nAS=1 and BUSY=0 asynchronously, no DONE; a subsequent REQ completes normally.
